// File: rtl/flag_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : flag_unit_pkg
// Brief   : Shared CPU definitions: ALU op encodings, NZCV flag-bit indices
//           and small op-classification helpers used by the decoder and the
//           flag unit.
// Revision: 1.0  initial release
// ============================================================================
package flag_unit_pkg;

    typedef logic [2:0] alu_op_t;

    // ALU operation encodings
    localparam alu_op_t OP_ADD   = 3'b000;
    localparam alu_op_t OP_ADC   = 3'b001;
    localparam alu_op_t OP_SUB   = 3'b010;
    localparam alu_op_t OP_SBC   = 3'b011;
    localparam alu_op_t OP_RSB   = 3'b100;
    localparam alu_op_t OP_RSC   = 3'b101;
    localparam alu_op_t OP_LOGIC = 3'b110;
    localparam alu_op_t OP_MUL   = 3'b111;

    // Bit positions inside a {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Ops that go through the adder and produce their own C and V
    function automatic logic op_is_arith(input alu_op_t op);
        return (op != OP_LOGIC) && (op != OP_MUL);
    endfunction

    // Reverse-subtract forms swap the operands before inversion
    function automatic logic op_is_reverse(input alu_op_t op);
        return (op == OP_RSB) || (op == OP_RSC);
    endfunction

    // Subtract forms add the one's complement of the subtrahend
    function automatic logic op_inverts(input alu_op_t op);
        return (op == OP_SUB) || (op == OP_SBC) || (op == OP_RSB) || (op == OP_RSC);
    endfunction

    // Carry-consuming forms take the live C flag as carry-in
    function automatic logic op_uses_carry(input alu_op_t op);
        return (op == OP_ADC) || (op == OP_SBC) || (op == OP_RSC);
    endfunction

endpackage : flag_unit_pkg
`default_nettype wire

// File: rtl/flag_unit_add_flags.sv
`default_nettype none
// ============================================================================
// Module  : add_flags
// Brief   : W+1-bit adder x + y + cin producing the W-bit sum, the carry-out
//           (bit W) and signed overflow.
// Revision: 1.0  initial release
// ============================================================================
module add_flags #(
    parameter int W = 32
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         ovf_o
);

    logic [W:0] w_sum;

    // Full-width add with the carry-in folded into the LSB
    always_comb begin
        w_sum  = {1'b0, x_i} + {1'b0, y_i} + {{W{1'b0}}, cin_i};
        sum_o  = w_sum[W-1:0];
        cout_o = w_sum[W];
        // Overflow: operands agree in sign but the result sign differs
        ovf_o  = (x_i[W-1] == y_i[W-1]) && (w_sum[W-1] != x_i[W-1]);
    end

endmodule : add_flags
`default_nettype wire

// File: rtl/flag_unit.sv
`default_nettype none
// ============================================================================
// Module  : flag_unit
// Brief   : Registered ALU result and NZCV flag register with a shadow copy
//           for exception entry/return and a direct flag-write port.
//           Flag writer priority: exc_return > msr_we > ALU set-flags.
// Revision: 1.0  initial release
// ============================================================================
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [2:0]   in_op,
    input  logic         in_s,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic [W-1:0] logic_res,
    input  logic         shift_c,
    input  logic         msr_we,
    input  logic [3:0]   msr_nzcv,
    input  logic         exc_entry,
    input  logic         exc_return,
    output logic [W-1:0] res,
    output logic         res_valid,
    output logic         n,
    output logic         z,
    output logic         c,
    output logic         v,
    output logic [3:0]   spsr_nzcv
);

    logic [W-1:0] res_q, res_d;
    logic         res_valid_q;
    logic [3:0]   flags_q, flags_d;
    logic [3:0]   spsr_q, spsr_d;

    logic [W-1:0] w_x, w_y, w_sum, w_res;
    logic         w_cin, w_cout, w_ovf;
    logic         w_alu_c, w_alu_v;
    logic [3:0]   w_alu_nzcv;

    // Adder operand steering; carry-consuming ops read the registered C
    always_comb begin
        w_x   = op_a;
        w_y   = op_b;
        w_cin = 1'b0;
        if (op_is_reverse(in_op)) begin
            w_x = op_b;
            w_y = ~op_a;
        end else if (op_inverts(in_op)) begin
            w_y = ~op_b;
        end
        if (op_uses_carry(in_op)) begin
            w_cin = flags_q[FLAG_C];
        end else if (op_inverts(in_op)) begin
            w_cin = 1'b1;
        end
    end

    add_flags #(
        .W (W)
    ) u_add_flags (
        .x_i    (w_x),
        .y_i    (w_y),
        .cin_i  (w_cin),
        .sum_o  (w_sum),
        .cout_o (w_cout),
        .ovf_o  (w_ovf)
    );

    // Result and ALU-proposed flags; LOGIC/MUL keep flags they do not own
    always_comb begin
        w_alu_c = flags_q[FLAG_C];
        w_alu_v = flags_q[FLAG_V];
        if (op_is_arith(in_op)) begin
            w_res   = w_sum;
            w_alu_c = w_cout;
            w_alu_v = w_ovf;
        end else begin
            w_res = logic_res;
            if (in_op == OP_LOGIC) begin
                w_alu_c = shift_c;
            end
        end
        w_alu_nzcv         = 4'b0000;
        w_alu_nzcv[FLAG_N] = w_res[W-1];
        w_alu_nzcv[FLAG_Z] = (w_res == '0);
        w_alu_nzcv[FLAG_C] = w_alu_c;
        w_alu_nzcv[FLAG_V] = w_alu_v;
    end

    // Next-state selection: prioritised flag writers, shadow save of old flags
    always_comb begin
        res_d = in_valid ? w_res : res_q;
        if (exc_return) begin
            flags_d = spsr_q;
        end else if (msr_we) begin
            flags_d = msr_nzcv;
        end else if (in_valid && in_s) begin
            flags_d = w_alu_nzcv;
        end else begin
            flags_d = flags_q;
        end
        spsr_d = exc_entry ? flags_q : spsr_q;
    end

    // State registers, cleared asynchronously so in-flight work is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q       <= '0;
            res_valid_q <= 1'b0;
            flags_q     <= 4'b0000;
            spsr_q      <= 4'b0000;
        end else begin
            res_q       <= res_d;
            res_valid_q <= in_valid;
            flags_q     <= flags_d;
            spsr_q      <= spsr_d;
        end
    end

    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign n         = flags_q[FLAG_N];
    assign z         = flags_q[FLAG_Z];
    assign c         = flags_q[FLAG_C];
    assign v         = flags_q[FLAG_V];
    assign spsr_nzcv = spsr_q;

endmodule : flag_unit
`default_nettype wire

// File: tb/tb_flag_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_flag_unit
// Brief   : Self-checking bench for flag_unit: directed vectors with literal
//           expectations plus a behavioural model compared every cycle.
// Revision: 1.0  initial release
// ============================================================================
module tb_flag_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [2:0]   in_op;
    logic         in_s;
    logic [W-1:0] op_a, op_b, logic_res;
    logic         shift_c;
    logic         msr_we;
    logic [3:0]   msr_nzcv;
    logic         exc_entry, exc_return;
    logic [W-1:0] res;
    logic         res_valid, n, z, c, v;
    logic [3:0]   spsr_nzcv;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    flag_unit #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_op     (in_op),
        .in_s      (in_s),
        .op_a      (op_a),
        .op_b      (op_b),
        .logic_res (logic_res),
        .shift_c   (shift_c),
        .msr_we    (msr_we),
        .msr_nzcv  (msr_nzcv),
        .exc_entry (exc_entry),
        .exc_return(exc_return),
        .res       (res),
        .res_valid (res_valid),
        .n         (n),
        .z         (z),
        .c         (c),
        .v         (v),
        .spsr_nzcv (spsr_nzcv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_res;
    logic         m_rv;
    logic [3:0]   m_f, m_sp, nf;
    logic [W-1:0] mx, my, mr;
    int           mci;
    longint       us, ss;
    logic         mc, mv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_res = '0; m_rv = 1'b0; m_f = 4'b0; m_sp = 4'b0;
        end else begin
            nf = m_f;
            mr = m_res; mc = m_f[1]; mv = m_f[0];
            if (in_valid) begin
                mx = op_a; my = op_b; mci = 0;
                case (in_op)
                    3'd1: mci = int'(m_f[1]);
                    3'd2: begin my = ~op_b; mci = 1; end
                    3'd3: begin my = ~op_b; mci = int'(m_f[1]); end
                    3'd4: begin mx = op_b; my = ~op_a; mci = 1; end
                    3'd5: begin mx = op_b; my = ~op_a; mci = int'(m_f[1]); end
                    default: ;
                endcase
                if (in_op < 3'd6) begin
                    us = longint'(mx) + longint'(my) + longint'(mci);
                    ss = longint'($signed(mx)) + longint'($signed(my)) + longint'(mci);
                    mr = us[31:0];
                    mc = (us >= 64'sh1_0000_0000);
                    mv = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
                end else begin
                    mr = logic_res;
                    if (in_op == 3'd6) mc = shift_c;
                end
                m_res = mr;
            end
            m_rv = in_valid;
            if (exc_return)                nf = m_sp;
            else if (msr_we)               nf = msr_nzcv;
            else if (in_valid && in_s)     nf = {mr[31], (mr == 0), mc, mv};
            if (exc_entry) m_sp = m_f;
            m_f = nf;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("model.res",       64'(res),       64'(m_res));
            chk("model.res_valid", 64'(res_valid), 64'(m_rv));
            chk("model.nzcv",      64'({n, z, c, v}), 64'(m_f));
            chk("model.spsr",      64'(spsr_nzcv), 64'(m_sp));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        in_valid = 0; in_op = 0; in_s = 0; op_a = 0; op_b = 0; logic_res = 0;
        shift_c = 0; msr_we = 0; msr_nzcv = 0; exc_entry = 0; exc_return = 0;
    endtask

    // Apply one cycle of inputs (called at a negedge), return at next negedge
    task automatic cyc(input logic vld, input logic [2:0] op, input logic s,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] lr, input logic sc,
                       input logic mwe, input logic [3:0] mval,
                       input logic ent, input logic ret);
        in_valid = vld; in_op = op; in_s = s; op_a = a; op_b = b; logic_res = lr;
        shift_c = sc; msr_we = mwe; msr_nzcv = mval; exc_entry = ent; exc_return = ret;
        @(negedge clk);
        idle();
    endtask

    task automatic alu(input logic [2:0] op, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b);
        cyc(1, op, s, a, b, '0, 0, 0, 4'h0, 0, 0);
    endtask

    task automatic msr(input logic [3:0] val);
        cyc(0, 0, 0, '0, '0, '0, 0, 1, val, 0, 0);
    endtask

    task automatic chk_flags(input string name, input logic [3:0] exp);
        chk(name, 64'({n, z, c, v}), 64'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("reset.res", 64'(res), 64'h0);
        chk("reset.res_valid", 64'(res_valid), 64'h0);
        chk_flags("reset.nzcv", 4'b0000);
        chk("reset.spsr", 64'(spsr_nzcv), 64'h0);
        rst_n = 1;
        chk_en = 1;
        @(negedge clk);

        // ADD overflow into sign bit
        alu(3'd0, 1, 32'h7FFF_FFFF, 32'h1);
        chk("add_ovf.res", 64'(res), 64'h8000_0000);
        chk("add_ovf.res_valid", 64'(res_valid), 64'h1);
        chk_flags("add_ovf.nzcv", 4'b1001);

        // SUB equal, then SBC with C=1 and C=0
        alu(3'd2, 1, 32'd5, 32'd5);
        chk("sub_eq.res", 64'(res), 64'h0);
        chk_flags("sub_eq.nzcv", 4'b0110);
        alu(3'd3, 1, 32'd0, 32'd0);
        chk("sbc_c1.res", 64'(res), 64'h0);
        chk_flags("sbc_c1.nzcv", 4'b0110);
        alu(3'd0, 1, 32'd0, 32'd0);            // clears C
        chk_flags("add_zero.nzcv", 4'b0100);
        alu(3'd3, 1, 32'd0, 32'd0);
        chk("sbc_c0.res", 64'(res), 64'hFFFF_FFFF);
        chk_flags("sbc_c0.nzcv", 4'b1000);

        // RSB / RSC
        alu(3'd4, 1, 32'd3, 32'd10);
        chk("rsb.res", 64'(res), 64'd7);
        chk_flags("rsb.nzcv", 4'b0010);
        alu(3'd5, 1, 32'd3, 32'd10);
        chk("rsc.res", 64'(res), 64'd7);

        // LOGIC with V preset
        msr(4'b0001);
        cyc(1, 3'd6, 1, '0, '0, 32'h0, 1, 0, 4'h0, 0, 0);
        chk("logic_s1.res", 64'(res), 64'h0);
        chk_flags("logic_s1.nzcv", 4'b0111);
        msr(4'b1000);
        cyc(1, 3'd6, 0, '0, '0, 32'h0, 1, 0, 4'h0, 0, 0);
        chk("logic_s0.res", 64'(res), 64'h0);
        chk_flags("logic_s0.nzcv", 4'b1000);

        // MUL keeps C and V
        msr(4'b0011);
        cyc(1, 3'd7, 1, '0, '0, 32'h8000_0000, 0, 0, 4'h0, 0, 0);
        chk_flags("mul.nzcv", 4'b1011);

        // Shadow save / direct write / restore
        msr(4'b1010);
        cyc(0, 0, 0, '0, '0, '0, 0, 0, 4'h0, 1, 0);
        chk("entry.spsr", 64'(spsr_nzcv), 64'hA);
        chk_flags("entry.nzcv", 4'b1010);
        msr(4'b0101);
        chk_flags("msr.nzcv", 4'b0101);
        cyc(0, 0, 0, '0, '0, '0, 0, 0, 4'h0, 0, 1);
        chk_flags("return.nzcv", 4'b1010);

        // Back-to-back carry dependency
        alu(3'd0, 1, 32'hFFFF_FFFF, 32'd1);
        alu(3'd1, 1, 32'd1, 32'd1);
        chk("adc_dep.res", 64'(res), 64'd3);

        // Writer priority with spsr 0000
        msr(4'b0000);
        cyc(0, 0, 0, '0, '0, '0, 0, 0, 4'h0, 1, 0);
        msr(4'b1100);
        cyc(1, 3'd0, 1, 32'd0, 32'd0, '0, 0, 1, 4'hF, 0, 1);
        chk_flags("prio.nzcv", 4'b0000);
        chk("prio.res", 64'(res), 64'h0);
        chk("prio.res_valid", 64'(res_valid), 64'h1);

        // Entry with simultaneous write, then swap
        msr(4'b1100);
        cyc(0, 0, 0, '0, '0, '0, 0, 1, 4'b0011, 1, 0);
        chk("entry_wr.spsr", 64'(spsr_nzcv), 64'hC);
        chk_flags("entry_wr.nzcv", 4'b0011);
        cyc(0, 0, 0, '0, '0, '0, 0, 0, 4'h0, 1, 1);
        chk("swap.spsr", 64'(spsr_nzcv), 64'h3);
        chk_flags("swap.nzcv", 4'b1100);

        // Mixed vectors checked by the model
        for (int i = 0; i < 40; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom),
                (i % 5 == 0) ? 32'h8000_0000 : 32'($urandom),
                (i % 7 == 0) ? 32'h7FFF_FFFF : 32'($urandom),
                (i % 3 == 0) ? 32'h0 : 32'($urandom), 1'($urandom),
                1'($urandom_range(0, 5) == 0), 4'($urandom),
                1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0));
        end

        // Asynchronous reset mid-cycle after an S op
        alu(3'd0, 1, 32'hFFFF_FFFF, 32'h1);
        chk_en = 0;
        #2 rst_n = 0;
        #1;
        chk("async.res", 64'(res), 64'h0);
        chk("async.res_valid", 64'(res_valid), 64'h0);
        chk_flags("async.nzcv", 4'b0000);
        chk("async.spsr", 64'(spsr_nzcv), 64'h0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk_en = 1;
        alu(3'd0, 0, 32'd2, 32'd3);
        chk("post_rst.res", 64'(res), 64'd5);
        chk_flags("post_rst.nzcv", 4'b0000);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_flag_unit
`default_nettype wire
